led_rate_ctrl: RTL and testbench
================================

Name: led_rate_ctrl

Overview:
Controller that sequences the divided-clock LED counter on the icestick.
- Two raw push-buttons, each debounced on-chip, drive a run/pause state machine and select one of four count rates (1x, 2x, 4x, 8x BASE_HZ).
- Generates a single-cycle tick enable from the 12 MHz oscillator and advances a 4-bit LED count on each tick.
- Everything runs in the `clk` domain; there are no derived clocks.

Parameters:
- CLK_HZ, 12000000, oscillator frequency in Hz.
- BASE_HZ, 1, slowest tick rate in Hz, used when rate=0.
- DEBOUNCE_CYCLES, 120000, consecutive stable samples required before a button level is accepted.

Ports:
- clk  input  1  12 MHz oscillator; the only clock.
- rst  input  1  synchronous, active-high reset.
- btn_run_n  input  1  raw run/pause button, active-low, asynchronous to clk.
- btn_rate_n  input  1  raw rate button, active-low, asynchronous to clk.
- led  output  4  LED count value.
- tick  output  1  one-cycle pulse on each count advance.
- running  output  1  high while in RUN.
- rate  output  2  current rate select; tick frequency = BASE_HZ << rate.

Behaviour:
- Reset: sampled on the clk rising edge only.
  - Outputs: led=0, tick=0, running=0, rate=0.
  - Internal: FSM=STOPPED, divider=0, synchroniser and debounced levels=1 (released), debounce counters=0.
  - Reset asserted mid-operation takes effect at the next edge and discards any pending press.
- Input path, per button:
  - 2-flop synchroniser.
  - Debounce counter increments while the synced sample differs from the debounced level; it clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the sample still differs, debounced level <= sample and counter <= 0.
- Press event: one-cycle internal pulse, registered in the same edge as the debounced level falls 1->0. Release generates nothing.
  - Latency from a clean raw edge to the pulse is 2+DEBOUNCE_CYCLES cycles.
- Terminal count: TC(r) = CLK_HZ/(BASE_HZ<<r) - 1.
  - Divider width is clog2(CLK_HZ/BASE_HZ).
  - Elaboration must fail if CLK_HZ/(BASE_HZ*8) < 2.
- FSM states and transitions:
  - STOPPED: divider held at 0, led held. run press -> RUN.
  - RUN: divider counts 0..TC(rate). When divider==TC, divider<=0, tick=1 that cycle, and led<=led+1 (new value visible the next cycle). Tick period is exactly TC+1 cycles; the first tick comes TC+1 cycles after entering RUN from STOPPED. run press -> PAUSED.
  - PAUSED: divider and led hold their values. run press -> RUN, resuming from the held divider value.
- running=1 only in RUN. tick is 0 outside RUN.
- led wraps 15 -> 0 with no flag.
- rate press in any state:
  - rate <= rate+1, wrapping 3 -> 0.
  - divider <= 0.
  - If this coincides with a divider==TC cycle in RUN, the tick and led increment still happen, using the old TC.
- Simultaneous run and rate press in one cycle: both apply in that edge (state transition, rate increment, divider clear).

Optional Feature:
- Macro: PAUSE_BLINK_EN.
- Defined: a blink phase flop is set to 1 on entry to PAUSED. It toggles every CLK_HZ/BASE_HZ cycles, using its own counter that is cleared on PAUSED entry.
  - In PAUSED, led output = held count when phase=1, and 0 when phase=0.
  - The internal count is unaffected; leaving PAUSED restores direct output in the same cycle.
- Not defined: led always shows the count register; there is no blink logic.

Test Plan:
Bench parameters: CLK_HZ=64, BASE_HZ=1, DEBOUNCE_CYCLES=4, so TC = 63/31/15/7.
- Reset then idle 200 cycles -> led=0, tick never 1, running=0, rate=0.
- Clean run press held 10 cycles -> running=1 exactly 6 cycles after the raw fall. Ticks occur every 64 cycles. led=1 after the first tick; after 16 ticks led=0 (wrap).
- Bounce run button (toggle every 2 cycles for 12 cycles, then steady low) -> exactly one press is accepted and running=1 once.
- In RUN, press rate 3 times -> rate=3 and tick period 8. A 4th press gives rate=0 and period 64. The divider restarts at each press, so the next tick comes TC+1 cycles after the rate pulse.
- Press run in RUN, then hold 100 cycles -> running=0, led frozen, no tick. Press run again -> ticks resume, and the first tick arrives TC+1 minus the divider value held at pause.
- Assert rst for 1 cycle mid-RUN with led=9 and rate=2 -> next cycle led=0, rate=0, running=0, tick=0. With PAUSE_BLINK_EN, in PAUSED with led=5, observe led alternating 5 and 0 every 64 cycles.

Source files
------------

// File: rtl/led_rate_ctrl.sv
// led_rate_ctrl: debounced run/pause and rate buttons drive a ticking 4-bit LED counter; define PAUSE_BLINK_EN to blink the LEDs while paused.
// Latency: a button acts 2+DEBOUNCE_CYCLES clk edges after a clean raw edge; tick is combinational from the divider state.
// Backpressure: none; the block is free-running and tick is a bare strobe with no handshake.
module led_rate_ctrl #(
    parameter int CLK_HZ          = 12000000,
    parameter int BASE_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run_n,
    input  logic       btn_rate_n,
    output logic [3:0] led,
    output logic       tick,
    output logic       running,
    output logic [1:0] rate
);
    localparam int DIV_N = CLK_HZ / BASE_HZ;
    localparam int DIV_W = $clog2(DIV_N);
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] TC0     = DIV_W'(CLK_HZ / BASE_HZ - 1);
    localparam logic [DIV_W-1:0] TC1     = DIV_W'(CLK_HZ / (BASE_HZ * 2) - 1);
    localparam logic [DIV_W-1:0] TC2     = DIV_W'(CLK_HZ / (BASE_HZ * 4) - 1);
    localparam logic [DIV_W-1:0] TC3     = DIV_W'(CLK_HZ / (BASE_HZ * 8) - 1);

    generate
        if (CLK_HZ / (BASE_HZ * 8) < 2) begin : g_bad_cfg
            $error("led_rate_ctrl: CLK_HZ/(BASE_HZ*8) must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    // Bit 0 is the run button, bit 1 the rate button.
    logic [1:0]      btn_raw;
    logic [1:0]      sync_a;
    logic [1:0]      sync_b;
    logic [1:0]      level;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press;

    assign btn_raw = {btn_rate_n, btn_run_n};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a    <= '1;
            sync_b    <= '1;
            level     <= '1;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press fires in the same edge that the debounced level falls; releases are ignored.
    always_comb begin
        press = '0;
        for (int i = 0; i < 2; i++) begin
            press[i] = level[i] & ~sync_b[i] & (db_cnt[i] == DB_LAST);
        end
    end

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] tc;
    logic [3:0]       count_q;
    logic [3:0]       count_nxt;
    logic [1:0]       rate_q;
    logic [1:0]       rate_nxt;
    logic             tick_c;

    always_comb begin
        case (rate_q)
            2'd0:    tc = TC0;
            2'd1:    tc = TC1;
            2'd2:    tc = TC2;
            default: tc = TC3;
        endcase
    end

    always_comb begin
        state_nxt = state;
        div_nxt   = div_q;
        count_nxt = count_q;
        rate_nxt  = rate_q;
        tick_c    = 1'b0;
        case (state)
            STOPPED: begin
                div_nxt = '0;
                if (press[0]) state_nxt = RUN;
            end
            RUN: begin
                if (div_q == tc) begin
                    div_nxt   = '0;
                    tick_c    = 1'b1;
                    count_nxt = count_q + 4'd1;
                end else begin
                    div_nxt = div_q + 1'b1;
                end
                if (press[0]) state_nxt = PAUSED;
            end
            PAUSED: begin
                if (press[0]) state_nxt = RUN;
            end
            default: state_nxt = STOPPED;
        endcase
        // A rate change restarts the divider; a coincident tick above keeps the old TC.
        if (press[1]) begin
            rate_nxt = rate_q + 2'd1;
            div_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= STOPPED;
            div_q   <= '0;
            count_q <= '0;
            rate_q  <= '0;
        end else begin
            state   <= state_nxt;
            div_q   <= div_nxt;
            count_q <= count_nxt;
            rate_q  <= rate_nxt;
        end
    end

    assign tick    = tick_c;
    assign running = (state == RUN);
    assign rate    = rate_q;

`ifdef PAUSE_BLINK_EN
    logic             blink_phase;
    logic [DIV_W-1:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_phase <= 1'b1;
            blink_cnt   <= '0;
        end else if (state_nxt == PAUSED && state != PAUSED) begin
            blink_phase <= 1'b1;
            blink_cnt   <= '0;
        end else if (state == PAUSED) begin
            if (blink_cnt == TC0) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign led = (state == PAUSED && !blink_phase) ? 4'd0 : count_q;
`else
    assign led = count_q;
`endif

endmodule

// File: tb/tb_led_rate_ctrl.sv
// tb_led_rate_ctrl: directed bench for led_rate_ctrl at CLK_HZ=64, BASE_HZ=1, DEBOUNCE_CYCLES=4 (TC = 63/31/15/7).
// Latency: outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Backpressure: not applicable; every wait is bounded by a cycle budget.
module tb_led_rate_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run_n = 1'b1;
    logic       btn_rate_n = 1'b1;
    logic [3:0] led;
    logic       tick;
    logic       running;
    logic [1:0] rate;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_rate_ctrl #(
        .CLK_HZ(64),
        .BASE_HZ(1),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_run_n(btn_run_n),
        .btn_rate_n(btn_rate_n),
        .led(led),
        .tick(tick),
        .running(running),
        .rate(rate)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int seen_tick = 0;
        int seen_run = 0;
        int seen_led = 0;
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        checks++; if (led !== 4'd0) begin failures++; $display("FAIL reset_led: got %0d expected 0", led); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %0b expected 0", tick); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running: got %0b expected 0", running); end
        checks++; if (rate !== 2'd0) begin failures++; $display("FAIL reset_rate: got %0d expected 0", rate); end
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (tick !== 1'b0) seen_tick++;
            if (running !== 1'b0) seen_run++;
            if (led !== 4'd0) seen_led++;
        end
        checks++; if (seen_tick != 0) begin failures++; $display("FAIL idle_tick: tick cycles %0d expected 0", seen_tick); end
        checks++; if (seen_run != 0) begin failures++; $display("FAIL idle_running: running cycles %0d expected 0", seen_run); end
        checks++; if (seen_led != 0) begin failures++; $display("FAIL idle_led: nonzero led cycles %0d expected 0", seen_led); end
        checks++; if (rate !== 2'd0) begin failures++; $display("FAIL idle_rate: got %0d expected 0", rate); end
    endtask

    task automatic test_run_press();
        logic       r5 = 1'b1;
        logic       r6 = 1'b0;
        logic [3:0] led1 = 4'hF;
        int idx = 0;
        int ntick = 0;
        int last = 0;
        int first = -1;
        int bad = 0;
        btn_run_n = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i == 5) r5 = running;
            if (i == 6) r6 = running;
        end
        checks++; if (r5 !== 1'b0) begin failures++; $display("FAIL run_early: running=%0b after 5 edges expected 0", r5); end
        checks++; if (r6 !== 1'b1) begin failures++; $display("FAIL run_rise: running=%0b after 6 edges expected 1", r6); end
        // idx 0 is the first RUN cycle with the divider at 0.
        while (ntick < 16 && idx < 1200) begin
            if (tick === 1'b1) begin
                if (ntick == 0) first = idx;
                else if (idx - last != 64) bad++;
                last = idx;
                ntick++;
            end
            cyc();
            idx++;
            if (idx == 4) btn_run_n = 1'b1;
            if (ntick == 1 && idx == last + 1) led1 = led;
        end
        checks++; if (ntick != 16) begin failures++; $display("FAIL run_tick_count: got %0d ticks expected 16", ntick); end
        checks++; if (first != 63) begin failures++; $display("FAIL run_first_tick: at RUN cycle %0d expected 63", first); end
        checks++; if (led1 !== 4'd1) begin failures++; $display("FAIL run_led_first: got %0d expected 1", led1); end
        checks++; if (bad != 0) begin failures++; $display("FAIL run_period: %0d periods differ from expected 64", bad); end
        checks++; if (led !== 4'd0) begin failures++; $display("FAIL run_wrap: led=%0d expected 0 after 16 ticks", led); end
    endtask

    task automatic test_bounce();
        int rises = 0;
        int rise_at = -1;
        logic prev;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        prev = running;
        for (int i = 0; i < 12; i++) begin
            btn_run_n = ((i % 4) < 2) ? 1'b0 : 1'b1;
            cyc();
            if (running === 1'b1 && prev !== 1'b1) rises++;
            prev = running;
        end
        btn_run_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (running === 1'b1 && prev !== 1'b1) begin
                rises++;
                if (rise_at < 0) rise_at = k;
            end
            prev = running;
        end
        btn_run_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (running === 1'b1 && prev !== 1'b1) rises++;
            prev = running;
        end
        checks++; if (rises != 1) begin failures++; $display("FAIL bounce_rises: got %0d expected 1", rises); end
        checks++; if (rise_at != 6) begin failures++; $display("FAIL bounce_latency: rise after %0d steady edges expected 6", rise_at); end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL bounce_running: got %0b expected 1", running); end
    endtask

    task automatic test_rate();
        logic [1:0] exp_rate [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        int         exp_per [4] = '{32, 16, 8, 64};
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            int m = 0;
            int held = 0;
            logic [1:0] r0 = rate;
            logic [3:0] led_ref;
            btn_rate_n = 1'b0;
            while (rate === r0 && n < 20) begin
                cyc(); n++; held++;
            end
            checks++; if (n != 6 || rate !== exp_rate[k]) begin
                failures++; $display("FAIL rate_step%0d: rate=%0d after %0d edges expected %0d after 6", k, rate, n, exp_rate[k]);
            end
            // Divider restarts on the rate edge, so the next led step is TC+1 cycles away.
            for (int p = 0; p < 2; p++) begin
                led_ref = led;
                m = 0;
                while (led === led_ref && m < 200) begin
                    cyc(); m++; held++;
                    if (held == 10) btn_rate_n = 1'b1;
                end
                checks++; if (m != exp_per[k]) begin
                    failures++; $display("FAIL rate_period%0d_%0d: got %0d cycles expected %0d", k, p, m, exp_per[k]);
                end
            end
        end
    endtask

    task automatic test_pause();
        int n = 0;
        int step = 0;
        int run_cyc = 0;
        int paused = 0;
        int bad_led = 0;
        int bad_tick = 0;
        int got = 0;
        logic [3:0] frozen = 4'd0;
        logic [3:0] exp_led;
        logic [3:0] exp_next;
        while (tick !== 1'b1 && n < 200) begin
            cyc(); n++;
        end
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL pause_sync: tick=%0b expected 1", tick); end
        while (got == 0 && step < 400) begin
            cyc();
            step++;
            if (running === 1'b1) begin
                run_cyc++;
                if (tick === 1'b1) got = 1;
            end else begin
                if (paused == 0) frozen = led;
`ifdef PAUSE_BLINK_EN
                exp_led = (paused < 64) ? frozen : 4'd0;
`else
                exp_led = frozen;
`endif
                if (led !== exp_led) bad_led++;
                if (tick !== 1'b0) bad_tick++;
                paused++;
            end
            if (step == 20) btn_run_n = 1'b0;
            if (step == 30) btn_run_n = 1'b1;
            if (step == 130) btn_run_n = 1'b0;
            if (step == 140) btn_run_n = 1'b1;
        end
        checks++; if (got != 1) begin failures++; $display("FAIL pause_resume_tick: no tick within %0d cycles", step); end
        checks++; if (paused != 110) begin failures++; $display("FAIL pause_length: paused %0d cycles expected 110", paused); end
        checks++; if (run_cyc != 64) begin failures++; $display("FAIL pause_divider_hold: %0d RUN cycles between ticks expected 64", run_cyc); end
        checks++; if (bad_led != 0) begin failures++; $display("FAIL pause_led: %0d cycles with wrong led, held %0d", bad_led, frozen); end
        checks++; if (bad_tick != 0) begin failures++; $display("FAIL pause_tick: %0d ticks while paused expected 0", bad_tick); end
        exp_next = frozen + 4'd1;
        cyc();
        checks++; if (led !== exp_next) begin failures++; $display("FAIL pause_led_advance: got %0d expected %0d", led, exp_next); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int stray = 0;
        for (int k = 0; k < 2; k++) begin
            btn_rate_n = 1'b0;
            repeat (10) cyc();
            btn_rate_n = 1'b1;
            repeat (12) cyc();
        end
        checks++; if (rate !== 2'd2 || running !== 1'b1) begin
            failures++; $display("FAIL rstmid_setup: rate=%0d running=%0b expected 2 and 1", rate, running);
        end
        while (led !== 4'd9 && n < 400) begin
            cyc(); n++;
        end
        checks++; if (led !== 4'd9) begin failures++; $display("FAIL rstmid_led9: got %0d expected 9", led); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (led !== 4'd0) begin failures++; $display("FAIL rstmid_led: got %0d expected 0", led); end
        checks++; if (rate !== 2'd0) begin failures++; $display("FAIL rstmid_rate: got %0d expected 0", rate); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL rstmid_running: got %0b expected 0", running); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL rstmid_tick: got %0b expected 0", tick); end
        for (int i = 0; i < 80; i++) begin
            cyc();
            if (tick !== 1'b0 || running !== 1'b0 || led !== 4'd0) stray++;
        end
        checks++; if (stray != 0) begin failures++; $display("FAIL rstmid_idle: %0d active cycles expected 0", stray); end
    endtask

`ifdef PAUSE_BLINK_EN
    task automatic test_blink();
        int n = 0;
        int held = 0;
        logic [3:0] l0 = 4'hF;
        logic [3:0] l63 = 4'hF;
        logic [3:0] l64 = 4'hF;
        logic [3:0] l128 = 4'hF;
        logic [3:0] l197 = 4'hF;
        logic [3:0] l198 = 4'hF;
        logic       r198 = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        btn_run_n = 1'b0;
        while (led !== 4'd5 && n < 600) begin
            cyc(); n++;
            if (n == 10) btn_run_n = 1'b1;
        end
        btn_run_n = 1'b0;
        n = 0;
        while (running !== 1'b0 && n < 20) begin
            cyc(); n++; held++;
        end
        l0 = led;
        for (int idx = 1; idx <= 198; idx++) begin
            cyc();
            held++;
            if (held == 10) btn_run_n = 1'b1;
            if (idx == 63) l63 = led;
            if (idx == 64) l64 = led;
            if (idx == 128) l128 = led;
            if (idx == 197) l197 = led;
            if (idx == 198) begin l198 = led; r198 = running; end
            if (idx == 192) btn_run_n = 1'b0;
        end
        btn_run_n = 1'b1;
        checks++; if (l0 !== 4'd5) begin failures++; $display("FAIL blink_entry: got %0d expected 5", l0); end
        checks++; if (l63 !== 4'd5) begin failures++; $display("FAIL blink_63: got %0d expected 5", l63); end
        checks++; if (l64 !== 4'd0) begin failures++; $display("FAIL blink_64: got %0d expected 0", l64); end
        checks++; if (l128 !== 4'd5) begin failures++; $display("FAIL blink_128: got %0d expected 5", l128); end
        checks++; if (l197 !== 4'd0) begin failures++; $display("FAIL blink_dark: got %0d expected 0", l197); end
        checks++; if (r198 !== 1'b1 || l198 !== 4'd5) begin
            failures++; $display("FAIL blink_resume: running=%0b led=%0d expected 1 and 5", r198, l198);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_run_press();
        test_bounce();
        test_rate();
        test_pause();
        test_reset_mid();
`ifdef PAUSE_BLINK_EN
        test_blink();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
